uart_tx: RTL and testbench

UART serial transmitter, the counterpart of the team's `uart_rx`. It accepts a parallel word over a valid/ready handshake and serialises it on `tx` as start bit, data LSB-first, optional parity, and stop bit(s), at `BAUD_DIV` clocks per bit. It sits between on-chip logic (loopback, command responder) and the board's TX pin. Its frame format matches `uart_rx` when both use the same parameters.

---
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits.
// First start-bit clock follows the accepting edge; tx_valid is ignored (never queued) while a frame is in flight.
module uart_tx #(
    parameter int unsigned BAUD_DIV      = 1250,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned ENABLE_PARITY = 0,
    parameter int unsigned PARITY_ODD    = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(DATA_BITS) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [CW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 baud_wrap;

    assign baud_wrap = (baud_q == BW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        rdy_d   = rdy_q;
        done_d  = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                rdy_d = 1'b1;
                if (tx_valid && rdy_q) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    rdy_d   = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = tx_data;
                    // Parity is fixed at capture so later tx_data changes cannot leak in
                    par_d   = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == CW'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (ENABLE_PARITY != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_wrap) begin
                    if (bit_q == CW'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                        done_d  = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                rdy_d   = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        busy_d = ~rdy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = rdy_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks per bit.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] vld, rdy, txw, bsy, dn;
    logic [7:0] dat [4];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [8:0] q0[$], q1[$], q2[$], q3[$];
    int start_cyc [4] = '{default: 0};
    int prev_start [4] = '{default: 0};
    bit mon_busy [4] = '{default: 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .ENABLE_PARITY(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_valid(vld[0]), .tx_data(dat[0]),
        .tx_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .ENABLE_PARITY(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(vld[1]), .tx_data(dat[1]),
        .tx_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .ENABLE_PARITY(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_valid(vld[2]), .tx_data(dat[2]),
        .tx_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]), .tx_done(dn[2]));
    uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .ENABLE_PARITY(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .tx_valid(vld[3]), .tx_data(dat[3]),
        .tx_ready(rdy[3]), .tx(txw[3]), .busy(bsy[3]), .tx_done(dn[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void qpush(input int i, input logic [8:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [8:0] qpop(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    // Expected item is {parity_bit, data}; the parity bit is ignored by no-parity instances.
    task automatic mon(input int i, input int nbits, input bit has_par);
        bit pend = 1'b0;
        forever begin
            logic [8:0] e;
            logic       lv [12];
            bit         ok;
            bit         abort;
            if (!pend) @(negedge clk);
            pend = 1'b0;
            if (rst_n !== 1'b1 || txw[i] !== 1'b0) continue;
            mon_busy[i]   = 1'b1;
            prev_start[i] = start_cyc[i];
            start_cyc[i]  = cyc;
            checks++;
            if (qsize(i) == 0) begin
                errors++;
                $display("FAIL inst%0d unexpected frame: got start bit, expected idle line", i);
                for (int w = 0; w < 200 && rdy[i] !== 1'b1; w++) @(negedge clk);
                mon_busy[i] = 1'b0;
                continue;
            end
            e = qpop(i);
            lv[0] = 1'b0;
            for (int k = 0; k < 8; k++) lv[1+k] = e[k];
            for (int k = 9; k < 12; k++) lv[k] = 1'b1;
            if (has_par) lv[9] = e[8];
            abort = 1'b0;
            for (int b = 0; b < nbits && !abort; b++) begin
                ok = 1'b1;
                for (int c = 0; c < B; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    if (txw[i] !== lv[b] || rdy[i] !== 1'b0 || bsy[i] !== 1'b1 || dn[i] !== 1'b0) ok = 1'b0;
                end
                if (!abort) chk($sformatf("inst%0d byte %02h bit%0d", i, e[7:0], b), 32'(ok), 32'd1);
            end
            if (!abort) begin
                @(negedge clk);
                if (rst_n === 1'b1)
                    chk($sformatf("inst%0d done/ready/tx/busy after %02h", i, e[7:0]),
                        32'({dn[i], rdy[i], txw[i], bsy[i]}), 32'b1110);
                @(negedge clk);
                chk($sformatf("inst%0d done single cycle", i), 32'(dn[i]), 32'd0);
                pend = 1'b1;
            end
            mon_busy[i] = 1'b0;
        end
    endtask

    initial mon(0, 10, 1'b0);
    initial mon(1, 11, 1'b1);
    initial mon(2, 11, 1'b1);
    initial mon(3, 11, 1'b0);

    task automatic send(input int i, input logic [7:0] d, input logic p, input bit hold);
        int n = 0;
        @(negedge clk);
        dat[i] = d;
        vld[i] = 1'b1;
        while (rdy[i] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("inst%0d ready for %02h", i, d), 32'(rdy[i]), 32'd1);
        qpush(i, {p, d});
        @(posedge clk);
        #1;
        if (!hold) vld[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((qsize(i) != 0 || mon_busy[i] || rdy[i] !== 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("inst%0d drain within budget", i), 32'(n < 1000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vld = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset tx", 32'(txw), 32'hF);
        chk("reset tx_ready", 32'(rdy), 32'hF);
        chk("reset busy", 32'(bsy), 32'h0);
        chk("reset tx_done", 32'(dn), 32'h0);
        rst_n = 1'b1;

        // Basic 8N1 frame
        send(0, 8'hA5, 1'b0, 1'b0);
        wait_idle(0);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        send(1, 8'h07, 1'b1, 1'b0);
        send(2, 8'h07, 1'b0, 1'b0);
        wait_idle(1);
        wait_idle(2);

        // Back-to-back with tx_valid held: period F+1 = 41
        send(0, 8'h55, 1'b0, 1'b1);
        send(0, 8'h0F, 1'b0, 1'b0);
        wait_idle(0);
        chk("inst0 back-to-back start spacing", 32'(start_cyc[0] - prev_start[0]), 32'd41);

        // Offer 0xFF mid-frame and scramble tx_data: only 0x00 goes out
        send(0, 8'h00, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 8'hFF;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (5) @(negedge clk);
        dat[0] = 8'hAA;
        wait_idle(0);
        repeat (20) @(negedge clk);
        chk("inst0 no queued frame", 32'({rdy[0], txw[0], bsy[0]}), 32'b110);

        // Reset during data bit 3 (bit3 of 0xF0 is 0, so tx is low beforehand)
        send(0, 8'hF0, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        chk("inst0 tx in data bit3 before reset", 32'(txw[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("inst0 async reset tx/ready/busy/done", 32'({txw[0], rdy[0], bsy[0], dn[0]}), 32'b1100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("inst0 no done after reset", 32'({dn[0], txw[0]}), 32'b01);
        send(0, 8'h3C, 1'b0, 1'b0);
        wait_idle(0);

        // Two stop bits, back-to-back: period (1+8+2)*4+1 = 45
        send(3, 8'h00, 1'b0, 1'b1);
        send(3, 8'hFF, 1'b0, 1'b1);
        send(3, 8'h81, 1'b0, 1'b0);
        wait_idle(3);
        chk("inst3 back-to-back start spacing", 32'(start_cyc[3] - prev_start[3]), 32'd45);

        repeat (10) @(negedge clk);
        chk("all expected frames seen", 32'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
